// File: rtl/ws2812_rx_decoder.sv
// rtl/ws2812_rx_decoder.sv - WS2812 NRZ receiver: pulse-width bit decode, GRB pixel packing, frame-gap detection
// Optional cascade output on dout is built only when WS2812_RX_PASSTHRU_EN is defined.
module ws2812_rx_decoder #(
  parameter int T_MIN     = 8,
  parameter int T_THRESH  = 30,
  parameter int T_MAX     = 60,
  parameter int RESET_CYC = 2500,
  parameter int CNT_W     = 16,
  parameter int IDX_W     = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             din,
  output logic             pixel_valid,
  output logic [7:0]       data_g,
  output logic [7:0]       data_r,
  output logic [7:0]       data_b,
  output logic [IDX_W-1:0] pixel_idx,
  output logic             frame_done,
  output logic             rx_err,
  output logic             dout
);

  typedef enum logic [1:0] {ST_SYNC, ST_LOW, ST_HIGH} state_t;

  localparam logic [CNT_W-1:0] C_MIN    = CNT_W'(T_MIN);
  localparam logic [CNT_W-1:0] C_THRESH = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(T_MAX);
  localparam logic [CNT_W-1:0] C_GAP    = CNT_W'(RESET_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  state_t           state_q, state_d;
  logic             din_m_q, din_s_q, din_d_q;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0] high_cnt_inc, low_cnt_inc;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [23:0]      shift_q, shift_d;
  logic [IDX_W-1:0] next_idx_q, next_idx_d;
  logic [IDX_W-1:0] pixel_idx_q, pixel_idx_d;
  logic [7:0]       data_g_q, data_g_d;
  logic [7:0]       data_r_q, data_r_d;
  logic [7:0]       data_b_q, data_b_d;
  logic             pixel_valid_q, pixel_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             rx_err_q, rx_err_d;
  logic             rise, fall, bit_val, clear_frame;

  assign rise         = din_s_q & ~din_d_q;
  assign fall         = ~din_s_q & din_d_q;
  assign high_cnt_inc = high_cnt_q + CNT_W'(1);
  assign low_cnt_inc  = low_cnt_q + CNT_W'(1);
  assign bit_val      = (high_cnt_q >= C_THRESH);

  always_comb begin
    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    next_idx_d    = next_idx_q;
    pixel_idx_d   = pixel_idx_q;
    data_g_d      = data_g_q;
    data_r_d      = data_r_q;
    data_b_d      = data_b_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    rx_err_d      = 1'b0;
    clear_frame   = 1'b0;
    case (state_q)
      // Nothing is decoded until the line has been idle-low for a full gap.
      ST_SYNC: begin
        if (din_s_q) begin
          low_cnt_d = '0;
        end else if (low_cnt_inc == C_GAP) begin
          low_cnt_d = C_GAP;
          state_d   = ST_LOW;
        end else begin
          low_cnt_d = low_cnt_inc;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d    = ST_HIGH;
          high_cnt_d = CNT_W'(1);
          low_cnt_d  = '0;
        end else if (low_cnt_q != C_GAP) begin
          low_cnt_d = low_cnt_inc;
          if (low_cnt_inc == C_GAP) begin
            frame_done_d = (bit_cnt_q != 5'd0) || (next_idx_q != '0);
            rx_err_d     = (bit_cnt_q != 5'd0);
            clear_frame  = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (fall) begin
          low_cnt_d = '0;
          if (high_cnt_q < C_MIN) begin
            rx_err_d    = 1'b1;
            state_d     = ST_SYNC;
            clear_frame = 1'b1;
          end else begin
            state_d = ST_LOW;
            shift_d = {shift_q[22:0], bit_val};
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d     = 5'd0;
              pixel_valid_d = 1'b1;
              data_g_d      = shift_d[23:16];
              data_r_d      = shift_d[15:8];
              data_b_d      = shift_d[7:0];
              pixel_idx_d   = next_idx_q;
              next_idx_d    = (next_idx_q == IDX_LAST) ? next_idx_q : next_idx_q + IDX_W'(1);
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end else if (high_cnt_inc >= C_MAX) begin
          rx_err_d    = 1'b1;
          state_d     = ST_SYNC;
          low_cnt_d   = '0;
          clear_frame = 1'b1;
        end else begin
          high_cnt_d = high_cnt_inc;
        end
      end
      default: state_d = ST_SYNC;
    endcase
    if (clear_frame) begin
      bit_cnt_d  = 5'd0;
      next_idx_d = '0;
    end
  end

`ifdef WS2812_RX_PASSTHRU_EN
  logic pass_q, pass_d;

  // Chain element: pixel 0 of each frame is consumed, the rest is forwarded.
  always_comb begin
    pass_d = pass_q;
    if (clear_frame) begin
      pass_d = 1'b0;
    end else if (pixel_valid_d) begin
      pass_d = 1'b1;
    end
  end

  assign dout = pass_q & din_s_q;
`else
  assign dout = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_SYNC;
      din_m_q       <= 1'b0;
      din_s_q       <= 1'b0;
      din_d_q       <= 1'b0;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      bit_cnt_q     <= 5'd0;
      shift_q       <= 24'd0;
      next_idx_q    <= '0;
      pixel_idx_q   <= '0;
      data_g_q      <= 8'd0;
      data_r_q      <= 8'd0;
      data_b_q      <= 8'd0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      rx_err_q      <= 1'b0;
`ifdef WS2812_RX_PASSTHRU_EN
      pass_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      din_m_q       <= din;
      din_s_q       <= din_m_q;
      din_d_q       <= din_s_q;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      next_idx_q    <= next_idx_d;
      pixel_idx_q   <= pixel_idx_d;
      data_g_q      <= data_g_d;
      data_r_q      <= data_r_d;
      data_b_q      <= data_b_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      rx_err_q      <= rx_err_d;
`ifdef WS2812_RX_PASSTHRU_EN
      pass_q        <= pass_d;
`endif
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign data_g      = data_g_q;
  assign data_r      = data_r_q;
  assign data_b      = data_b_q;
  assign pixel_idx   = pixel_idx_q;
  assign frame_done  = frame_done_q;
  assign rx_err      = rx_err_q;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// tb/tb_ws2812_rx_decoder.sv - directed table-driven bench for ws2812_rx_decoder
// Passthrough expectations switch with WS2812_RX_PASSTHRU_EN.
module tb_ws2812_rx_decoder;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       din;
  logic       pixel_valid;
  logic [7:0] data_g, data_r, data_b;
  logic [7:0] pixel_idx;
  logic       frame_done, rx_err, dout;

  int n_checks = 0;
  int n_fail   = 0;
  int pv_cnt = 0, fd_cnt = 0, err_cnt = 0, both_cnt = 0;
  int dout_bad = 0, dout_hi = 0;
  logic [7:0] cap_g = 8'd0, cap_r = 8'd0, cap_b = 8'd0, cap_idx = 8'd0;
  logic din_h1 = 1'b0, din_h2 = 1'b0;
  logic dout_phase = 1'b0;
`ifdef WS2812_RX_PASSTHRU_EN
  logic dout_chk = 1'b0;
`else
  logic dout_chk = 1'b1;
`endif

  typedef struct {
    logic [23:0] pix;
    bit          gap_after;
    logic [7:0]  exp_g;
    logic [7:0]  exp_r;
    logic [7:0]  exp_b;
    logic [7:0]  exp_idx;
    int          exp_fd;
  } vec_t;

  vec_t vecs[4];

  ws2812_rx_decoder dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .din         (din),
    .pixel_valid (pixel_valid),
    .data_g      (data_g),
    .data_r      (data_r),
    .data_b      (data_b),
    .pixel_idx   (pixel_idx),
    .frame_done  (frame_done),
    .rx_err      (rx_err),
    .dout        (dout)
  );

  always #10 sys_clk = ~sys_clk;

  // dout should equal din two cycles back when mirroring, else 0.
  always @(negedge sys_clk) begin
    if (pixel_valid) begin
      pv_cnt  <= pv_cnt + 1;
      cap_g   <= data_g;
      cap_r   <= data_r;
      cap_b   <= data_b;
      cap_idx <= pixel_idx;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (rx_err) err_cnt <= err_cnt + 1;
    if (rx_err && frame_done) both_cnt <= both_cnt + 1;
    if (dout_chk) begin
      if (dout !== (dout_phase ? din_h2 : 1'b0)) dout_bad <= dout_bad + 1;
      if (dout === 1'b1) dout_hi <= dout_hi + 1;
    end
    din_h1 <= din;
    din_h2 <= din_h1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int th;
    th = b ? 40 : 20;
    din = 1'b1;
    repeat (th) @(posedge sys_clk);
    #1 din = 1'b0;
    repeat (62 - th) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_bits(input logic [23:0] px, input int nbits);
    for (int k = 0; k < nbits; k++) send_bit(px[23 - k]);
  endtask

  task automatic send_pixel(input logic [23:0] px);
    send_bits(px, 24);
  endtask

  initial begin
    int p0, e0, f0, b0;

    vecs[0] = '{24'hA53C0F, 1'b0, 8'hA5, 8'h3C, 8'h0F, 8'd0, 0};
    vecs[1] = '{24'h123456, 1'b0, 8'h12, 8'h34, 8'h56, 8'd1, 0};
    vecs[2] = '{24'hFF0080, 1'b1, 8'hFF, 8'h00, 8'h80, 8'd2, 1};
    vecs[3] = '{24'h00FF01, 1'b1, 8'h00, 8'hFF, 8'h01, 8'd0, 2};

    sys_rst_n = 1'b0;
    din = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_pixel_valid", pixel_valid, 0);
    check("reset_data", {data_g, data_r, data_b}, 0);
    check("reset_idx", pixel_idx, 0);
    check("reset_strobes", {frame_done, rx_err, dout}, 0);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Pulses before the first idle gap must be ignored.
    send_bits(24'hF0F0F0, 6);
    idle(2600);
    check("pre_idle_no_pixel", pv_cnt, 0);
    check("pre_idle_no_err", err_cnt, 0);

    for (int i = 0; i < 4; i++) begin
      p0 = pv_cnt;
      send_pixel(vecs[i].pix);
      idle(5);
      check("vec_pixel_count", pv_cnt, p0 + 1);
      check("vec_data_g", cap_g, vecs[i].exp_g);
      check("vec_data_r", cap_r, vecs[i].exp_r);
      check("vec_data_b", cap_b, vecs[i].exp_b);
      check("vec_idx", cap_idx, vecs[i].exp_idx);
      if (vecs[i].gap_after) idle(2600);
      check("vec_frame_done", fd_cnt, vecs[i].exp_fd);
      check("vec_no_err", err_cnt, 0);
    end

    p0 = pv_cnt; e0 = err_cnt; f0 = fd_cnt;
    send_pixel(24'h010203);
    send_bits(24'hABCDEF, 10);
    din = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1 din = 1'b0;
    repeat (30) @(posedge sys_clk);
    #1;
    idle(2600);
    check("glitch_err", err_cnt, e0 + 1);
    check("glitch_pixels", pv_cnt, p0 + 1);
    check("glitch_no_frame_done", fd_cnt, f0);
    send_pixel(24'hABCDEF);
    idle(5);
    check("recover_pixel", pv_cnt, p0 + 2);
    check("recover_data", {cap_g, cap_r, cap_b}, 32'h00ABCDEF);
    check("recover_idx", cap_idx, 0);
    idle(2600);
    check("recover_frame_done", fd_cnt, f0 + 1);

    p0 = pv_cnt; e0 = err_cnt; f0 = fd_cnt; b0 = both_cnt;
    din = 1'b1;
    repeat (61) @(posedge sys_clk);
    @(negedge sys_clk);
    check("stuck_before_max", rx_err, 0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("stuck_at_max", rx_err, 1);
    repeat (38) @(posedge sys_clk);
    #1 din = 1'b0;
    idle(2600);
    check("stuck_err_count", err_cnt, e0 + 1);
    check("stuck_no_frame_done", fd_cnt, f0);
    send_bits(24'h5A5A5A, 12);
    idle(2600);
    check("partial_err", err_cnt, e0 + 2);
    check("partial_frame_done", fd_cnt, f0 + 1);
    check("partial_coincide", both_cnt, b0 + 1);
    check("partial_no_pixel", pv_cnt, p0);

    p0 = pv_cnt;
`ifdef WS2812_RX_PASSTHRU_EN
    dout_chk = 1'b1;
    dout_phase = 1'b0;
`endif
    send_pixel(24'hC31E77);
`ifdef WS2812_RX_PASSTHRU_EN
    dout_phase = 1'b1;
`endif
    send_pixel(24'h96E1A2);
`ifdef WS2812_RX_PASSTHRU_EN
    dout_chk = 1'b0;
    dout_phase = 1'b0;
    check("pass_dout_seen", (dout_hi > 0) ? 1 : 0, 1);
`endif
    idle(5);
    check("chain_pixels", pv_cnt, p0 + 2);
    check("chain_last_data", {cap_g, cap_r, cap_b}, 32'h0096E1A2);
    check("chain_last_idx", cap_idx, 1);
    idle(2600);
    check("dout_mismatch_cnt", dout_bad, 0);

    p0 = pv_cnt;
    send_pixel(24'h777777);
    send_bits(24'hFFFFFF, 10);
    check("pre_reset_data_g", data_g, 8'h77);
    sys_rst_n = 1'b0;
    #1;
    check("midreset_data", {data_g, data_r, data_b}, 0);
    check("midreset_strobes", {pixel_valid, frame_done, rx_err, dout}, 0);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    idle(2600);
    check("midreset_no_extra_pixel", pv_cnt, p0 + 1);
    send_pixel(24'h0A0B0C);
    idle(5);
    check("post_reset_data", {cap_g, cap_r, cap_b}, 32'h000A0B0C);
    check("post_reset_idx", cap_idx, 0);
`ifndef WS2812_RX_PASSTHRU_EN
    check("dout_never_high", dout_hi, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
